// File: rtl/bus_arbiter_rr_bp.sv
// bus_arbiter_rr_bp: shared-bus arbiter with round-robin/fixed-priority grant, destination backpressure, watchdog drop and delivery counter
module bus_arbiter_rr_bp #(
  parameter int DRVRS = 4,
  parameter int PCKG_SZ = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  input  logic [DRVRS-1:0]         dst_full,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [CNT_W-1:0]         pkt_cnt
);
  localparam int IW = DRVRS > 1 ? $clog2(DRVRS) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, POP, DELIVER} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] win, last, sel, idx;
  logic sel_ok, bad, blocked, deliver, timeout;
  logic [PCKG_SZ-1:0] hold, d_last;
  logic [WW-1:0] wcnt;
  logic [1:0] code_q;
  logic [7:0] dst;
  logic [DRVRS-1:0] mask;
  // winner search: first pending driver after the last grant (RR) or lowest pending index (fixed)
  always_comb begin
    sel = '0;
    sel_ok = 1'b0;
    idx = '0;
    for (int k = 1; k <= DRVRS; k++) begin
      idx = ARB_MODE != 0 ? IW'(k - 1) : IW'((int'(last) + k) % DRVRS);
      if (!sel_ok && pndng[idx]) begin
        sel = idx;
        sel_ok = 1'b1;
      end
    end
  end
  // destination decode of the held packet into a target mask, flagging unreachable destinations
  always_comb begin
    dst = hold[PCKG_SZ-1 -: 8];
    mask = '0;
    bad = 1'b0;
    if (dst == BROADCAST) begin
      mask = '1;
      mask[win] = 1'b0;
    end else if (32'(dst) < DRVRS && dst != 8'(win))
      mask[dst[IW-1:0]] = 1'b1;
    else
      bad = 1'b1;
  end
  // bus outputs, drop reporting and next-state; a broadcast is all-or-nothing
  always_comb begin
    blocked = |(dst_full & mask);
    deliver = state == DELIVER && !bad && !blocked;
    timeout = state == DELIVER && !bad && blocked && 32'(wcnt) + 1 >= MAX_WAIT;
    err = (state == DELIVER && bad) || timeout;
    err_code = err ? (bad ? 2'b01 : 2'b10) : code_q;
    pop = state == POP ? DRVRS'(1) << win : '0;
    push = deliver ? mask : '0;
    D_push = deliver ? hold : d_last;
    busy = state != IDLE;
    state_nxt = state == IDLE ? (sel_ok ? POP : IDLE) :
                state == POP ? DELIVER :
                (deliver || err) ? IDLE : DELIVER;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // grant, packet capture, wait counting and delivery bookkeeping
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      win <= '0;
      last <= IW'(DRVRS - 1);
      hold <= '0;
      d_last <= '0;
      wcnt <= '0;
      code_q <= '0;
      pkt_cnt <= '0;
    end else begin
      if (state == IDLE && sel_ok) win <= sel;
      if (state == POP) begin
        last <= win;
        hold <= D_pop[int'(win)*PCKG_SZ +: PCKG_SZ];
        wcnt <= '0;
      end
      if (state == DELIVER && !bad && blocked) wcnt <= wcnt + 1'b1;
      if (deliver) begin
        d_last <= hold;
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (err) code_q <= err_code;
    end
endmodule

// File: tb/tb_bus_arbiter_rr_bp.sv
// tb_bus_arbiter_rr_bp: directed-vector bench for the shared-bus arbiter
module tb_bus_arbiter_rr_bp;
  logic clk = 0, reset;
  logic [3:0] pndng, dst_full;
  logic [63:0] D_pop;
  logic [3:0] pop, push, pop_f, push_f, pop_c, push_c;
  logic [15:0] D_push, D_push_f, D_push_c;
  logic busy, err, busy_f, err_f, busy_c, err_c;
  logic [1:0] err_code, err_code_f, err_code_c, pkt_c2;
  logic [15:0] pkt_cnt, pkt_cnt_f;
  int vec = 0, miss = 0;
  always #5 clk = ~clk;
  bus_arbiter_rr_bp dut (.clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .dst_full(dst_full),
    .push(push), .D_push(D_push), .busy(busy), .err(err), .err_code(err_code), .pkt_cnt(pkt_cnt));
  bus_arbiter_rr_bp #(.ARB_MODE(1)) dut_f (.clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop_f),
    .dst_full(dst_full), .push(push_f), .D_push(D_push_f), .busy(busy_f), .err(err_f), .err_code(err_code_f),
    .pkt_cnt(pkt_cnt_f));
  bus_arbiter_rr_bp #(.CNT_W(2)) dut_c (.clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop_c),
    .dst_full(dst_full), .push(push_c), .D_push(D_push_c), .busy(busy_c), .err(err_c), .err_code(err_code_c),
    .pkt_cnt(pkt_c2));
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 0; pndng = 0; dst_full = 0; D_pop = 0;
    @(posedge clk);
    #1 reset = 1;
  endtask
  task automatic test_reset;
    reset = 0; pndng = 0; dst_full = 0; D_pop = 0;
    #3;
    vec++; if ({pop, push, busy, err, err_code} !== 12'h0) begin miss++; $display("FAIL reset_ctl: got %h expected 000", {pop, push, busy, err, err_code}); end
    vec++; if (pkt_cnt !== 16'h0) begin miss++; $display("FAIL reset_cnt: got %h expected 0000", pkt_cnt); end
    vec++; if (D_push !== 16'h0) begin miss++; $display("FAIL reset_dpush: got %h expected 0000", D_push); end
    @(posedge clk);
    #1 reset = 1;
  endtask
  task automatic test_single;
    do_reset;
    D_pop[32 +: 16] = 16'h01AB; pndng = 4'b0100;
    smp;
    vec++; if ({pop, busy} !== 5'b0) begin miss++; $display("FAIL single_idle: got %b expected 00000", {pop, busy}); end
    cyc; smp;
    vec++; if ({pop, busy} !== 5'b01001) begin miss++; $display("FAIL single_pop: got %b expected 01001", {pop, busy}); end
    cyc; pndng = 0; smp;
    vec++; if ({push, busy} !== 5'b00101) begin miss++; $display("FAIL single_push: got %b expected 00101", {push, busy}); end
    vec++; if (D_push !== 16'h01AB) begin miss++; $display("FAIL single_data: got %h expected 01AB", D_push); end
    cyc; smp;
    vec++; if ({push, busy, pkt_cnt} !== {5'b0, 16'd1}) begin miss++; $display("FAIL single_done: got %h expected %h", {push, busy, pkt_cnt}, {5'b0, 16'd1}); end
    vec++; if (D_push !== 16'h01AB) begin miss++; $display("FAIL single_hold: got %h expected 01AB", D_push); end
  endtask
  task automatic test_rr;
    logic [15:0] ev;
    do_reset;
    for (int i = 0; i < 4; i++) D_pop[i*16 +: 16] = {8'((i + 1) % 4), 8'(i)};
    pndng = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      ev = {8'((k % 4 + 1) % 4), 8'(k % 4)};
      cyc; smp;
      vec++; if (pop !== 4'(1) << (k % 4)) begin miss++; $display("FAIL rr_grant%0d: got %b expected %b", k, pop, 4'(1) << (k % 4)); end
      vec++; if (pop_f !== 4'b0001) begin miss++; $display("FAIL fixed_grant%0d: got %b expected 0001", k, pop_f); end
      cyc; smp;
      vec++; if ({push, D_push} !== {4'(1) << ((k % 4 + 1) % 4), ev}) begin miss++; $display("FAIL rr_push%0d: got %h expected %h", k, {push, D_push}, {4'(1) << ((k % 4 + 1) % 4), ev}); end
      vec++; if (push_f !== 4'b0010) begin miss++; $display("FAIL fixed_push%0d: got %b expected 0010", k, push_f); end
      cyc;
    end
    pndng = 0;
  endtask
  task automatic test_broadcast;
    do_reset;
    D_pop[16 +: 16] = 16'hFF55; pndng = 4'b0010;
    cyc; smp;
    vec++; if (pop !== 4'b0010) begin miss++; $display("FAIL bc_pop: got %b expected 0010", pop); end
    cyc; pndng = 0; smp;
    vec++; if ({push, D_push} !== {4'b1101, 16'hFF55}) begin miss++; $display("FAIL bc_push: got %h expected %h", {push, D_push}, {4'b1101, 16'hFF55}); end
    cyc; smp;
    vec++; if ({push, pkt_cnt} !== {4'b0, 16'd1}) begin miss++; $display("FAIL bc_cnt: got %h expected %h", {push, pkt_cnt}, {4'b0, 16'd1}); end
  endtask
  task automatic test_backpressure;
    do_reset;
    D_pop[0 +: 16] = 16'h03C3; dst_full = 4'b1000; pndng = 4'b0001;
    cyc; pndng = 0; smp;
    vec++; if (pop !== 4'b0001) begin miss++; $display("FAIL bp_pop: got %b expected 0001", pop); end
    for (int k = 1; k <= 5; k++) begin
      cyc; smp;
      vec++; if ({push, busy, err} !== 6'b000010) begin miss++; $display("FAIL bp_wait%0d: got %b expected 000010", k, {push, busy, err}); end
    end
    cyc; dst_full = 0; smp;
    vec++; if ({push, D_push} !== {4'b1000, 16'h03C3}) begin miss++; $display("FAIL bp_push: got %h expected %h", {push, D_push}, {4'b1000, 16'h03C3}); end
    cyc; smp;
    vec++; if ({busy, pkt_cnt} !== {1'b0, 16'd1}) begin miss++; $display("FAIL bp_cnt: got %h expected %h", {busy, pkt_cnt}, {1'b0, 16'd1}); end
    D_pop[0 +: 16] = 16'h03C4; dst_full = 4'b1000; pndng = 4'b0001;
    cyc; pndng = 0;
    for (int k = 1; k <= 7; k++) begin
      cyc; smp;
      vec++; if ({push, err} !== 5'b0) begin miss++; $display("FAIL to_wait%0d: got %b expected 00000", k, {push, err}); end
    end
    cyc; smp;
    vec++; if ({push, err, err_code} !== 7'b0000110) begin miss++; $display("FAIL to_err: got %b expected 0000110", {push, err, err_code}); end
    cyc; smp;
    vec++; if ({busy, err, err_code, pkt_cnt} !== {4'b0010, 16'd1}) begin miss++; $display("FAIL to_after: got %h expected %h", {busy, err, err_code, pkt_cnt}, {4'b0010, 16'd1}); end
    dst_full = 0;
  endtask
  task automatic test_bad_dest;
    do_reset;
    D_pop[0 +: 16] = 16'h0755; pndng = 4'b0001;
    cyc; pndng = 0; smp;
    vec++; if (pop !== 4'b0001) begin miss++; $display("FAIL bad7_pop: got %b expected 0001", pop); end
    cyc; smp;
    vec++; if ({push, err, err_code} !== 7'b0000101) begin miss++; $display("FAIL bad7_err: got %b expected 0000101", {push, err, err_code}); end
    cyc; smp;
    vec++; if ({busy, err, err_code, pkt_cnt} !== {4'b0001, 16'd0}) begin miss++; $display("FAIL bad7_after: got %h expected %h", {busy, err, err_code, pkt_cnt}, {4'b0001, 16'd0}); end
    D_pop[32 +: 16] = 16'h0222; pndng = 4'b0100;
    cyc; pndng = 0; smp;
    vec++; if (pop !== 4'b0100) begin miss++; $display("FAIL self_pop: got %b expected 0100", pop); end
    cyc; smp;
    vec++; if ({push, err, err_code} !== 7'b0000101) begin miss++; $display("FAIL self_err: got %b expected 0000101", {push, err, err_code}); end
    cyc;
  endtask
  task automatic test_reset_mid;
    do_reset;
    D_pop[0 +: 16] = 16'h0111; pndng = 4'b0001;
    cyc; pndng = 0; cyc; cyc; smp;
    vec++; if (pkt_cnt !== 16'd1) begin miss++; $display("FAIL rm_pre: got %0d expected 1", pkt_cnt); end
    D_pop[0 +: 16] = 16'h0333; dst_full = 4'b1000; pndng = 4'b0001;
    cyc; pndng = 0; smp;
    vec++; if (pop !== 4'b0001) begin miss++; $display("FAIL rm_pop: got %b expected 0001", pop); end
    cyc; cyc;
    #2 reset = 0;
    #1;
    vec++; if ({pop, push, busy, pkt_cnt, D_push} !== 41'h0) begin miss++; $display("FAIL rm_async: got %h expected 0", {pop, push, busy, pkt_cnt, D_push}); end
    pndng = 4'b1000; dst_full = 0; D_pop[48 +: 16] = 16'h0277;
    @(posedge clk);
    #1 reset = 1;
    cyc; pndng = 0; smp;
    vec++; if (pop !== 4'b1000) begin miss++; $display("FAIL rm_grant3: got %b expected 1000", pop); end
    cyc; smp;
    vec++; if ({push, D_push} !== {4'b0100, 16'h0277}) begin miss++; $display("FAIL rm_push3: got %h expected %h", {push, D_push}, {4'b0100, 16'h0277}); end
    cyc; reset = 0; pndng = 4'b1111; D_pop[0 +: 16] = 16'h0100;
    @(posedge clk);
    #1 reset = 1;
    cyc; smp;
    vec++; if (pop !== 4'b0001) begin miss++; $display("FAIL rm_grant0: got %b expected 0001", pop); end
    pndng = 0;
  endtask
  task automatic test_wrap;
    do_reset;
    D_pop[0 +: 16] = 16'h0111; pndng = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      cyc;
      if (k == 9) begin
        smp;
        vec++; if (pkt_c2 !== 2'd3) begin miss++; $display("FAIL wrap_three: got %0d expected 3", pkt_c2); end
      end
    end
    smp;
    vec++; if (pkt_c2 !== 2'd0) begin miss++; $display("FAIL wrap_zero: got %0d expected 0", pkt_c2); end
    vec++; if (pkt_cnt !== 16'd4) begin miss++; $display("FAIL wrap_wide: got %0d expected 4", pkt_cnt); end
    pndng = 0;
  endtask
  initial begin
    test_reset;
    test_single;
    test_rr;
    test_broadcast;
    test_backpressure;
    test_bad_dest;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr_bp.md
Name: bus_arbiter_rr_bp

Overview:
- Parametrised successor to the single-bus generator/arbiter: one shared bus serving DRVRS drivers, each with a source FIFO (pndng/pop/D_pop).
- Adds selectable round-robin or fixed-priority arbitration, per-destination backpressure (dst_full) with a watchdog timeout, explicit drop/error reporting, and a delivered-packet counter.
- Sits between the per-driver FIFOs and the per-driver receive FIFOs in the bus testbench environment.

Parameters:
- DRVRS, 4, number of drivers/ports (1..254).
- PCKG_SZ, 16, packet width in bits; bits [PCKG_SZ-1:PCKG_SZ-8] carry the destination ID (must be >= 9).
- BROADCAST, 8'hFF, destination ID that means deliver to every port except the source.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- MAX_WAIT, 8, maximum number of DELIVER cycles blocked by dst_full before the packet is dropped.
- CNT_W, 16, width of pkt_cnt.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  DRVRS  source FIFO i holds data; D_pop slice i is valid while pndng[i]=1 (first-word fall-through).
- D_pop  in  DRVRS*PCKG_SZ  source data; slice i = [i*PCKG_SZ +: PCKG_SZ].
- pop  out  DRVRS  one-cycle pulse that dequeues source i.
- dst_full  in  DRVRS  receive FIFO i cannot accept a push.
- push  out  DRVRS  one-cycle write strobe to receive FIFO(s).
- D_push  out  PCKG_SZ  shared bus data; valid while any push bit is 1.
- busy  out  1  FSM is not in IDLE.
- err  out  1  one-cycle pulse when a packet is dropped.
- err_code  out  2  cause of the drop: 01 = bad destination, 10 = timeout; held until the next err pulse.
- pkt_cnt  out  CNT_W  count of delivered packets (a broadcast counts as 1); wraps to 0 after its maximum value.

Behaviour:
- Reset (asynchronous, reset=0): immediately pop=0, push=0, D_push=0, busy=0, err=0, err_code=0, pkt_cnt=0, FSM=IDLE, wait counter=0.
  - RR pointer (last grant) = DRVRS-1, so driver 0 wins first.
  - Reset asserted mid-transaction aborts it: no pop/push completes, and the held packet is discarded.
- FSM states: IDLE, POP, DELIVER.
- IDLE, when pndng != 0:
  - Select the winner W. In RR mode, search from last+1 upward, wrapping modulo DRVRS. In fixed mode, take the lowest set index.
  - Register W and move to POP. Stay in IDLE while pndng == 0.
- POP: drive pop[W]=1 for exactly this cycle and capture D_pop slice W into the hold register. Update the RR pointer to W. Move to DELIVER.
- DELIVER: decode the destination ID d from the held packet.
  - Target mask: d == BROADCAST gives all ones except bit W. d < DRVRS and d != W gives one-hot d.
  - Any other d (d >= DRVRS and not BROADCAST, or d == W) is a bad destination: pulse err, set err_code=01, no push, go to IDLE.
  - If (dst_full & mask) == 0: drive push=mask and D_push=held packet for one cycle, increment pkt_cnt, go to IDLE.
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT, pulse err, set err_code=10, no push, go to IDLE.
  - A broadcast waits until every targeted destination is non-full; there are no partial pushes.
- Minimum latency: pndng seen at edge t, pop at cycle t+1, push at cycle t+2. Minimum bus period is 3 cycles per packet.
- pndng dropping during POP/DELIVER is ignored, because the data is already captured.
- D_push holds its last value when idle and returns to 0 only on reset.
- The wait counter clears on entry to DELIVER.
- DRVRS=1: every non-broadcast destination is bad, and a broadcast has an empty mask. An empty mask delivers immediately with push=0 and still counts in pkt_cnt.

Test Plan:
- Single delivery (DRVRS=4, PCKG_SZ=16): pndng=4'b0100, D_pop[2]=16'h01AB -> pop=4'b0100 at cycle 1, push=4'b0010 with D_push=16'h01AB at cycle 2, pkt_cnt=1, busy high for 2 cycles.
- Round-robin fairness: pndng=4'b1111 held, all packets to valid destinations -> grant order 0,1,2,3,0,1. Same stimulus with ARB_MODE=1 -> order 0,0,0,...
- Broadcast from driver 1: D_pop[1]=16'hFF55 -> push=4'b1101 in a single cycle, D_push=16'hFF55, pkt_cnt +1.
- Backpressure: packet to destination 3 with dst_full[3]=1 for 5 cycles -> push[3] occurs on the 6th DELIVER cycle. Same with dst_full[3] held 8 cycles (MAX_WAIT=8) -> err pulse, err_code=2'b10, no push, pkt_cnt unchanged.
- Bad destinations: destination 8'h07 -> err, err_code=01. Driver 2 sending to destination 2 -> err, err_code=01. In both cases pop still occurs.
- Reset mid-DELIVER (dst_full held) -> pop, push, busy, pkt_cnt go to 0 asynchronously. After release with pndng=4'b1000, driver 3 is granted; with pndng=4'b1111, driver 0 is granted first.
- pkt_cnt wrap with CNT_W=2: 4 deliveries -> pkt_cnt=0.
